// File: rtl/hcf_controller.sv
// hcf_controller: sequences the 16-bit HCF (GCD) datapath by repeated subtraction.
// Loads A then B from the upstream valid/ready source and steers the subtractor
// from the comparator flags until A==B. It reports done/err and the iteration count.
// Optional watchdog: define HCF_CTRL_WDOG_EN to abort after MAX_ITER subtractions.
//
// state  | meaning
// IDLE   | waiting for start, all controls low
// LOAD_A | accepting operand A from data_in
// LOAD_B | accepting operand B from data_in
// CALC   | one subtraction (or decision) per cycle from lt/gt/eq
// DONE   | one-cycle completion pulse
// ERR    | one-cycle completion pulse with err
module hcf_controller #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

`ifdef HCF_CTRL_WDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif
  // The subtraction performed while the count equals this limit is the last allowed.
  localparam logic [ITER_W-1:0] WDOG_LAST = ITER_W'(MAX_ITER - 1);

  state_t state, state_nxt;
  logic   iter_inc;
  logic   wdog_hit;

  assign wdog_hit = WDOG_EN && (iter_count == WDOG_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: cleared on an accepted start, saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count <= '0;
    end else if (state == IDLE && start) begin
      iter_count <= '0;
    end else if (iter_inc && iter_count != '1) begin
      iter_count <= iter_count + ITER_W'(1);
    end
  end

  // Next state plus Mealy datapath controls and Moore status outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    iter_inc  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldA       = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldB       = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        case ({lt, gt, eq})
          3'b001: state_nxt = DONE;
          3'b010: begin
            // A <= A - B
            sel2     = 1'b1;
            ldA      = 1'b1;
            iter_inc = 1'b1;
            if (wdog_hit) state_nxt = ERR;
          end
          3'b100: begin
            // B <= B - A
            sel1     = 1'b1;
            ldB      = 1'b1;
            iter_inc = 1'b1;
            if (wdog_hit) state_nxt = ERR;
          end
          default: state_nxt = ERR;
        endcase
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hcf_controller.sv
// tb_hcf_controller: directed bench for hcf_controller with a behavioural datapath.
// Build with HCF_CTRL_WDOG_EN defined to exercise the watchdog abort (MAX_ITER=8).
module tb_hcf_controller;

`ifdef HCF_CTRL_WDOG_EN
  localparam int TB_MAX = 8;
`else
  localparam int TB_MAX = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic        in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic        lt, gt, eq;
  logic [15:0] iter_count;
  logic [15:0] ra = '0, rb = '0;
  logic [15:0] opx, opy, bus;
  logic        ill = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hcf_controller #(.ITER_W(16), .MAX_ITER(TB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .lt(lt), .gt(gt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2),
    .sel_in(sel_in), .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  // Datapath model: registers A/B, subtractor x - y, bus mux, comparator
  assign opx = sel1 ? rb : ra;
  assign opy = sel2 ? rb : ra;
  assign bus = sel_in ? data_in : (opx - opy);
  assign lt  = ill ? 1'b1 : (ra < rb);
  assign gt  = ill ? 1'b1 : (ra > rb);
  assign eq  = ill ? 1'b0 : (ra == rb);

  always @(posedge clk) begin
    if (ldA) ra <= bus;
    if (ldB) rb <= bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Start with in_valid held high; optionally pulse start again during CALC
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int exp_n,
                     input logic [15:0] exp_h, input bit poke, input string tag);
    int cyc;
    int calc_loads;
    start = 1'b1; in_valid = 1'b1; data_in = a;
    nxt(); start = 1'b0; cyc = 1;
    #1;
    chk({tag, "_lda"}, {in_ready, sel_in, ldA, ldB}, 4'b1110);
    nxt(); data_in = b; cyc++;
    #1;
    chk({tag, "_ldb"}, {in_ready, sel_in, ldA, ldB}, 4'b1101);
    nxt(); cyc++;
    calc_loads = 0;
    if (poke) start = 1'b1;
    while (!done && cyc < 400) begin
      #1;
      if (ldA || ldB) calc_loads++;
      nxt(); start = 1'b0; cyc++;
    end
    chk({tag, "_lat"}, cyc, 32'(exp_n + 4));
    chk({tag, "_err"}, err, 0);
    chk({tag, "_iter"}, iter_count, 32'(exp_n));
    chk({tag, "_loads"}, calc_loads, exp_n);
    chk({tag, "_a"}, ra, exp_h);
    chk({tag, "_b"}, rb, exp_h);
  endtask

  initial begin
    int stall_ok;
    int busy_low;
    #12;
    chk("rst_busy", {busy, done, err, in_ready, ldA, ldB, sel_in}, 0);
    chk("rst_iter", iter_count, 0);
    rst_n = 1'b1;
    nxt();
    chk("idle_out", {busy, done, err, in_ready, ldA, ldB, sel1, sel2, sel_in}, 0);

    // 1: 48,18 -> 6 in four subtractions
    run(16'd48, 16'd18, 4, 16'd6, 1'b0, "t1");
    nxt();
    chk("t1_idle", busy, 0);
    chk("t1_iter_hold", iter_count, 4);

    // 2: equal operands; start during DONE must be ignored
    run(16'd7, 16'd7, 0, 16'd7, 1'b0, "t2");
    start = 1'b1;
    nxt(); start = 1'b0;
    chk("t2_start_in_done", busy, 0);
    nxt();
    chk("t2_still_idle", busy, 0);

    // 3: stalled input, 9 and 6
    in_valid = 1'b0; data_in = 16'd9; start = 1'b1;
    nxt(); start = 1'b0;
    stall_ok = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (!in_ready || ldA || ldB || !busy) stall_ok = 0;
      nxt();
    end
    chk("t3_stall_a", stall_ok, 1);
    in_valid = 1'b1; #1;
    chk("t3_lda", ldA, 1);
    nxt(); in_valid = 1'b0; data_in = 16'd6;
    stall_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (!in_ready || ldA || ldB) stall_ok = 0;
      nxt();
    end
    chk("t3_stall_b", stall_ok, 1);
    in_valid = 1'b1; #1;
    chk("t3_ldb", ldB, 1);
    for (int i = 0; i < 20 && !done; i++) nxt();
    chk("t3_done", {done, err}, 2'b10);
    chk("t3_res", {ra, rb}, {16'd3, 16'd3});
    chk("t3_iter", iter_count, 2);
    nxt();

    // 5: illegal flags in CALC
    start = 1'b1; data_in = 16'd20;
    nxt(); start = 1'b0;
    nxt(); data_in = 16'd8;
    nxt();
    ill = 1'b1; #1;
    chk("t5_noload", {ldA, ldB, in_ready}, 0);
    nxt(); ill = 1'b0;
    chk("t5_errpulse", {done, err, busy}, 3'b111);
    nxt();
    chk("t5_idle", {done, err, busy}, 0);

    // 4: zero operand, 0 and 5
    start = 1'b1; data_in = 16'd0;
    nxt(); start = 1'b0;
    nxt(); data_in = 16'd5;
    nxt();
`ifdef HCF_CTRL_WDOG_EN
    for (int i = 0; i < 40 && !done; i++) nxt();
    chk("t4_wdog_pulse", {done, err}, 2'b11);
    chk("t4_wdog_iter", iter_count, 8);
    nxt();
    chk("t4_wdog_idle", busy, 0);
`else
    busy_low = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy || done) busy_low++;
      nxt();
    end
    chk("t4_no_wdog_busy", busy_low, 0);
    chk("t4_no_wdog_iter", iter_count, 1000);
`endif

    // 6: reset mid-CALC, then fresh run with a start poke while busy
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    start = 1'b1; data_in = 16'd48; in_valid = 1'b1;
    nxt(); start = 1'b0;
    nxt(); data_in = 16'd18;
    nxt(); nxt();
    chk("t6_in_calc", {busy, sel_in}, 2'b10);
    rst_n = 1'b0; #1;
    chk("t6_rst_out", {busy, done, err, in_ready, ldA, ldB, sel1, sel2, sel_in}, 0);
    chk("t6_rst_iter", iter_count, 0);
    nxt(); rst_n = 1'b1;
    nxt();
    chk("t6_idle", busy, 0);
    run(16'd12, 16'd8, 2, 16'd4, 1'b1, "t6");
    nxt();
    chk("t6_after_poke", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
